ysyx_22040088_ifu: RTL

YSYX_22040088_IFU -- requirements
Module: ysyx_22040088_ifu

---
 rtl/ysyx_22040088_ifu.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry output
// register toward the decoder, redirect squashes in-flight or held fetches.
// Optional macro YSYX_22040088_IFU_ALIGN_CHK_EN: misaligned redirect targets
// are not fetched; a marked NOP is presented instead and the unit halts
// until the next redirect.
module ysyx_22040088_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] opc_q, opc_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;

  // Effective next fetch target: a redirect this cycle wins over the held pc.
  logic [63:0] tgt;
  logic        tgt_bad;
  logic        load_nop;
  logic        halt_on_ack;

  assign tgt = redirect_valid ? redirect_pc : pc_q;

`ifdef YSYX_22040088_IFU_ALIGN_CHK_EN
  logic mis_q, mis_d;
  assign tgt_bad      = (tgt[1:0] != 2'b00);
  assign halt_on_ack  = mis_q;
  assign out_misalign = mis_q;
`else
  assign tgt_bad      = 1'b0;
  assign halt_on_ack  = 1'b0;
  assign out_misalign = 1'b0;
`endif

  assign imem_req_addr = pc_q;
  assign out_pc        = opc_q;
  assign out_inst      = inst_q;

  // Next-state and handshake logic; redirect always takes priority.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    opc_d          = opc_q;
    inst_d         = inst_q;
    drop_d         = drop_q;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    load_nop       = 1'b0;
`ifdef YSYX_22040088_IFU_ALIGN_CHK_EN
    mis_d          = mis_q;
`endif
    unique case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) pc_d = redirect_pc;
        // A request accepted together with a redirect is for the old pc;
        // its response must be thrown away.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end else if (redirect_valid && tgt_bad) begin
          load_nop = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            // Stale response: discard, then refetch (or present a
            // misaligned marker if the pending target is bad).
            drop_d = 1'b0;
            if (tgt_bad) load_nop = 1'b1;
            else         state_d  = S_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            opc_d   = pc_q;
            state_d = S_OUT;
`ifdef YSYX_22040088_IFU_ALIGN_CHK_EN
            mis_d   = 1'b0;
`endif
          end
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (tgt_bad) load_nop = 1'b1;
          else         state_d  = S_REQ;
        end else if (out_ready) begin
          if (halt_on_ack) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + 64'd4;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (tgt_bad) load_nop = 1'b1;
          else         state_d  = S_REQ;
        end
      end
    endcase
    if (load_nop) begin
      state_d = S_OUT;
      opc_d   = tgt;
      inst_d  = NOP;
`ifdef YSYX_22040088_IFU_ALIGN_CHK_EN
      mis_d   = 1'b1;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      opc_q   <= RESET_PC;
      inst_q  <= NOP;
      drop_q  <= 1'b0;
`ifdef YSYX_22040088_IFU_ALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
`ifdef YSYX_22040088_IFU_ALIGN_CHK_EN
      mis_q   <= mis_d;
`endif
    end
  end

endmodule
